// File: rtl/add_seq.sv
// rtl/add_seq.sv - multi-word adder that reuses one 32-bit adder, one slice per cycle, LSW first
module adder_32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);
  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {32'b0, cin};
endmodule

module add_seq #(
  parameter int WORDS = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [32*WORDS-1:0]   in_a,
  input  logic [32*WORDS-1:0]   in_b,
  input  logic                  in_cin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [32*WORDS-1:0]   out_sum,
  output logic                  out_cout,
  output logic                  busy
);
  localparam int W  = 32 * WORDS;
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, state_nx;
  logic [W-1:0]    op_a, op_b;
  logic            carry;
  logic [IW-1:0]   idx;
  logic [31:0]     slice_a, slice_b, slice_sum;
  logic            slice_cout;
  logic            last;

  assign slice_a = op_a[32*idx +: 32];
  assign slice_b = op_b[32*idx +: 32];
  assign last    = (idx == IW'(WORDS - 1));

  adder_32 u_adder (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (carry),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_nx = RUN;
      end
      RUN: begin
        if (last) state_nx = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // idx returns to 0 after the top slice so it never selects past the operand
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a     <= '0;
      op_b     <= '0;
      carry    <= 1'b0;
      idx      <= '0;
      out_sum  <= '0;
      out_cout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_a     <= in_a;
            op_b     <= in_b;
            carry    <= in_cin;
            idx      <= '0;
            out_sum  <= '0;
            out_cout <= 1'b0;
          end
        end
        RUN: begin
          out_sum[32*idx +: 32] <= slice_sum;
          carry                 <= slice_cout;
          idx                   <= last ? '0 : idx + 1'b1;
          if (last) out_cout <= slice_cout;
        end
        default: begin
        end
      endcase
    end
  end
endmodule
